// File: rtl/waterfall_accum_buffer.sv
// Waterfall accumulation buffer: folds groups of 2^avg_log2 log-magnitude spectra into one
// display row (direct / peak-hold / average) and stores finished rows in a circular history
// that readers address by age (row 0 = newest committed row).
module waterfall_accum_buffer #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned NUM_BINS = 512,
    parameter int unsigned NUM_ROWS = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_W-1:0]             log_in,
    input  logic                          log_valid,
    input  logic                          log_last,
    input  logic [1:0]                    mode,
    input  logic [1:0]                    avg_log2,
    input  logic                          freeze,
    input  logic                          rd_req,
    input  logic [$clog2(NUM_BINS)-1:0]   rd_bin,
    input  logic [$clog2(NUM_ROWS)-1:0]   rd_row,
    output logic [DATA_W-1:0]             rd_data,
    output logic                          rd_valid,
    output logic [$clog2(NUM_ROWS)-1:0]   rows_filled,
    output logic                          row_commit,
    output logic                          frame_err
);

    localparam int unsigned BIN_W  = $clog2(NUM_BINS);
    localparam int unsigned ROW_W  = $clog2(NUM_ROWS);
    localparam int unsigned ACC_W  = DATA_W + 3;
    localparam int unsigned ADDR_W = ROW_W + BIN_W;
    localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);
    localparam logic [ROW_W-1:0] MAX_FILL = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        ModeDirect = 2'd0,
        ModePeak   = 2'd1,
        ModeAvg    = 2'd2
    } mode_e;

    // Encoding 11 is reserved and behaves as direct.
    function automatic mode_e norm_mode(input logic [1:0] m);
        case (m)
            2'd1:    return ModePeak;
            2'd2:    return ModeAvg;
            default: return ModeDirect;
        endcase
    endfunction

    // Storage
    logic [ACC_W-1:0]  acc_mem [NUM_BINS];
    logic [DATA_W-1:0] row_mem [NUM_ROWS * NUM_BINS];

    // Write-side framing state
    logic [BIN_W-1:0] wr_bin;
    logic [2:0]       spec_cnt;
    logic [ROW_W-1:0] wr_row;
    mode_e            grp_mode;
    logic [1:0]       grp_avg;
    logic             grp_frozen;

    // Read-modify-write pipeline stage
    logic             p_valid;
    logic [BIN_W-1:0] p_bin;
    logic [DATA_W-1:0] p_data;
    logic             p_first;
    logic             p_final;
    mode_e            p_mode;
    logic [1:0]       p_avg;
    logic             p_commit;
    logic [ACC_W-1:0] acc_rd;

    // Read pipeline stage
    logic              rd_pend;
    logic              rd_oob;
    logic [ADDR_W-1:0] rd_addr;

    logic             grp_start;
    mode_e            eff_mode;
    logic [1:0]       eff_avg;
    logic             eff_frozen;
    logic [2:0]       grp_top;
    logic             last_spec;
    logic             at_end;
    logic             beat_drop;
    logic             beat_err;
    logic             beat_ok;
    logic [ACC_W-1:0] acc_new;
    logic [ACC_W-1:0] acc_peak;
    logic [ACC_W-1:0] acc_sum;
    logic [ACC_W-1:0] acc_val;
    logic [DATA_W-1:0] row_val;

    // Beat classification; group controls come from the inputs only on the group's first beat.
    always_comb begin
        grp_start  = (wr_bin == '0) && (spec_cnt == 3'd0);
        eff_mode   = grp_start ? norm_mode(mode) : grp_mode;
        eff_avg    = grp_start ? avg_log2 : grp_avg;
        eff_frozen = grp_start ? freeze : grp_frozen;
        grp_top    = 3'((4'd1 << eff_avg) - 4'd1);
        last_spec  = (spec_cnt == grp_top);
        at_end     = (wr_bin == LAST_BIN);
        beat_drop  = log_valid && at_end && !log_last;
        beat_err   = log_valid && log_last && !at_end;
        beat_ok    = log_valid && !beat_drop && !beat_err;
    end

    // Combine the incoming bin with the accumulator for either the accumulator or a row.
    always_comb begin
        acc_new  = ACC_W'(p_data);
        acc_peak = (acc_rd > acc_new) ? acc_rd : acc_new;
        acc_sum  = acc_rd + acc_new;
        acc_val  = acc_new;
        row_val  = p_data;
        if (!p_first) begin
            case (p_mode)
                ModePeak: begin
                    acc_val = acc_peak;
                    row_val = acc_peak[DATA_W-1:0];
                end
                ModeAvg: begin
                    acc_val = acc_sum;
                    row_val = DATA_W'(acc_sum >> p_avg);
                end
                default: begin
                    acc_val = acc_new;
                    row_val = p_data;
                end
            endcase
        end
    end

    // Framing, pipeline, commit and read-control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bin      <= '0;
            spec_cnt    <= 3'd0;
            wr_row      <= '0;
            rows_filled <= '0;
            grp_mode    <= ModeDirect;
            grp_avg     <= 2'd0;
            grp_frozen  <= 1'b0;
            p_valid     <= 1'b0;
            p_bin       <= '0;
            p_data      <= '0;
            p_first     <= 1'b0;
            p_final     <= 1'b0;
            p_mode      <= ModeDirect;
            p_avg       <= 2'd0;
            p_commit    <= 1'b0;
            row_commit  <= 1'b0;
            frame_err   <= 1'b0;
            rd_pend     <= 1'b0;
            rd_oob      <= 1'b0;
            rd_addr     <= '0;
            rd_valid    <= 1'b0;
            rd_data     <= '0;
        end else begin
            frame_err <= beat_err;

            if (log_valid && grp_start) begin
                grp_mode   <= eff_mode;
                grp_avg    <= eff_avg;
                grp_frozen <= eff_frozen;
            end

            if (beat_err) begin
                // Short spectrum: abandon the group; stale accumulator data is overwritten later.
                wr_bin   <= '0;
                spec_cnt <= 3'd0;
            end else if (beat_ok) begin
                if (log_last) begin
                    wr_bin   <= '0;
                    spec_cnt <= last_spec ? 3'd0 : spec_cnt + 3'd1;
                end else begin
                    wr_bin <= wr_bin + BIN_W'(1);
                end
            end

            p_valid  <= beat_ok && !eff_frozen;
            p_bin    <= wr_bin;
            p_data   <= log_in;
            p_first  <= (spec_cnt == 3'd0);
            p_final  <= last_spec;
            p_mode   <= eff_mode;
            p_avg    <= eff_avg;
            p_commit <= beat_ok && !eff_frozen && log_last && last_spec;

            // The final bin's row write lands on this edge; advance the row alongside it.
            row_commit <= p_commit;
            if (p_commit) begin
                wr_row <= wr_row + ROW_W'(1);
                if (rows_filled != MAX_FILL) begin
                    rows_filled <= rows_filled + ROW_W'(1);
                end
            end

            rd_pend <= rd_req;
            if (rd_req) begin
                rd_addr <= {wr_row - ROW_W'(1) - rd_row, rd_bin};
                rd_oob  <= (rd_row >= rows_filled);
            end
            rd_valid <= rd_pend;
            if (rd_pend) begin
                rd_data <= rd_oob ? '0 : row_mem[rd_addr];
            end
        end
    end

    // Accumulator read for the incoming beat and write-back of the previous beat.
    always_ff @(posedge clk) begin
        if (log_valid) begin
            acc_rd <= acc_mem[wr_bin];
        end
        if (p_valid && !rst) begin
            if (p_final) begin
                row_mem[{wr_row, p_bin}] <= row_val;
            end else begin
                acc_mem[p_bin] <= acc_val;
            end
        end
    end

endmodule

// File: tb/tb_waterfall_accum_buffer.sv
// Self-checking bench for waterfall_accum_buffer: directed read tables and sequences plus
// randomized spectra checked against a group-level reference model.
module tb_waterfall_accum_buffer;

    localparam int DATA_W   = 8;
    localparam int NUM_BINS = 256;
    localparam int NUM_ROWS = 4;
    localparam int BIN_W    = $clog2(NUM_BINS);
    localparam int ROW_W    = $clog2(NUM_ROWS);

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] log_in;
    logic              log_valid;
    logic              log_last;
    logic [1:0]        mode;
    logic [1:0]        avg_log2;
    logic              freeze;
    logic              rd_req;
    logic [BIN_W-1:0]  rd_bin;
    logic [ROW_W-1:0]  rd_row;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [ROW_W-1:0]  rows_filled;
    logic              row_commit;
    logic              frame_err;

    waterfall_accum_buffer #(
        .DATA_W  (DATA_W),
        .NUM_BINS(NUM_BINS),
        .NUM_ROWS(NUM_ROWS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .log_in     (log_in),
        .log_valid  (log_valid),
        .log_last   (log_last),
        .mode       (mode),
        .avg_log2   (avg_log2),
        .freeze     (freeze),
        .rd_req     (rd_req),
        .rd_bin     (rd_bin),
        .rd_row     (rd_row),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rows_filled(rows_filled),
        .row_commit (row_commit),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int commit_seen = 0;
    int err_seen = 0;
    bit gaps = 1'b0;

    // Reference model: history by age, plus running sum/max of the open group.
    int m_rows [NUM_ROWS][NUM_BINS];
    int m_filled = 0;
    int m_commits = 0;
    int m_errs = 0;
    int g_n = 0;
    int g_mode = 0;
    int g_avg = 0;
    bit g_frz = 1'b0;
    int g_sum [NUM_BINS];
    int g_max [NUM_BINS];
    int spec [NUM_BINS];

    typedef struct {
        int row;
        int bin;
        int exp;
    } rd_vec_t;

    always @(negedge clk) begin
        if (row_commit === 1'b1) commit_seen++;
        if (frame_err === 1'b1) err_seen++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    function automatic int model_read(input int row, input int bin);
        return (row >= m_filled) ? 0 : m_rows[row][bin];
    endfunction

    task automatic model_reset();
        g_n = 0;
        m_filled = 0;
    endtask

    task automatic model_spectrum(input bit good);
        int row_v [NUM_BINS];
        if (!good) begin
            g_n = 0;
            m_errs++;
            return;
        end
        if (g_n == 0) begin
            g_mode = (mode == 2'd3) ? 0 : int'(mode);
            g_avg  = int'(avg_log2);
            g_frz  = freeze;
        end
        for (int b = 0; b < NUM_BINS; b++) begin
            if (g_n == 0) begin
                g_sum[b] = spec[b];
                g_max[b] = spec[b];
            end else begin
                g_sum[b] += spec[b];
                if (spec[b] > g_max[b]) g_max[b] = spec[b];
            end
        end
        g_n++;
        if (g_n == (1 << g_avg)) begin
            g_n = 0;
            if (!g_frz) begin
                for (int b = 0; b < NUM_BINS; b++) begin
                    case (g_mode)
                        1:       row_v[b] = g_max[b];
                        2:       row_v[b] = g_sum[b] / (1 << g_avg);
                        default: row_v[b] = spec[b];
                    endcase
                end
                for (int r = NUM_ROWS - 1; r > 0; r--) m_rows[r] = m_rows[r-1];
                m_rows[0] = row_v;
                if (m_filled < NUM_ROWS - 1) m_filled++;
                m_commits++;
            end
        end
    endtask

    task automatic beat(input int d, input bit last);
        if (gaps && ($urandom % 4 == 0)) begin
            @(negedge clk);
            log_valid = 1'b0;
            log_last  = 1'b0;
        end
        @(negedge clk);
        log_valid = 1'b1;
        log_in    = DATA_W'(d);
        log_last  = last;
    endtask

    // len < NUM_BINS: short spectrum; len > NUM_BINS: surplus beats before the last bin.
    task automatic send_spec(input int len);
        bit good;
        good = (len >= NUM_BINS);
        if (!good) begin
            for (int i = 0; i < len; i++) beat(spec[i], i == len - 1);
        end else begin
            for (int i = 0; i < NUM_BINS - 1; i++) beat(spec[i], 1'b0);
            for (int i = 0; i < len - NUM_BINS; i++) beat(int'($urandom % 256), 1'b0);
            beat(spec[NUM_BINS-1], 1'b1);
        end
        @(negedge clk);
        log_valid = 1'b0;
        log_last  = 1'b0;
        check("frame_err_after_last", frame_err, !good);
        model_spectrum(good);
    endtask

    task automatic settle();
        repeat (4) @(negedge clk);
    endtask

    task automatic check_state(input string nm);
        settle();
        check({nm, "_commits"}, commit_seen, m_commits);
        check({nm, "_frame_errs"}, err_seen, m_errs);
        check({nm, "_rows_filled"}, rows_filled, m_filled);
    endtask

    task automatic do_read(input int row, input int bin, input int exp, input string nm);
        @(negedge clk);
        rd_req = 1'b1;
        rd_row = ROW_W'(row);
        rd_bin = BIN_W'(bin);
        @(negedge clk);
        rd_req = 1'b0;
        check({nm, "_valid_early"}, rd_valid, 0);
        @(negedge clk);
        check({nm, "_valid"}, rd_valid, 1);
        check({nm, "_data"}, rd_data, exp);
        @(negedge clk);
        check({nm, "_valid_drop"}, rd_valid, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        log_valid = 1'b0;
        log_last  = 1'b0;
        rd_req    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        rd_vec_t tbl [8];
        int vals [4];
        tbl[0] = '{0, 5, 25};
        tbl[1] = '{1, 5, 15};
        tbl[2] = '{2, 5, 5};
        tbl[3] = '{3, 5, 0};
        tbl[4] = '{0, 0, 20};
        tbl[5] = '{0, 255, 19};
        tbl[6] = '{1, 250, 4};
        tbl[7] = '{2, 0, 0};
        vals[0] = 10; vals[1] = 20; vals[2] = 30; vals[3] = 41;

        rst = 1'b1; log_in = '0; log_valid = 1'b0; log_last = 1'b0;
        mode = 2'd0; avg_log2 = 2'd0; freeze = 1'b0;
        rd_req = 1'b0; rd_bin = '0; rd_row = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_rows_filled", rows_filled, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rd_data", rd_data, 0);
        check("reset_row_commit", row_commit, 0);
        check("reset_frame_err", frame_err, 0);

        // Direct, one spectrum per row
        for (int k = 0; k < 3; k++) begin
            for (int b = 0; b < NUM_BINS; b++) spec[b] = (10 * k + b) % 256;
            send_spec(NUM_BINS);
        end
        check_state("direct");
        check("direct_filled_3", rows_filled, 3);
        for (int i = 0; i < 8; i++) do_read(tbl[i].row, tbl[i].bin, tbl[i].exp, "direct_tbl");

        // Average then peak over groups of 4
        for (int pass = 0; pass < 2; pass++) begin
            mode = (pass == 0) ? 2'd2 : 2'd1;
            avg_log2 = 2'd2;
            for (int j = 0; j < 4; j++) begin
                for (int b = 0; b < NUM_BINS; b++) spec[b] = (3 * b + j) % 256;
                spec[7] = vals[j];
                send_spec(NUM_BINS);
                check_state(pass == 0 ? "avg_group" : "peak_group");
            end
            do_read(0, 7, (pass == 0) ? 25 : 41, pass == 0 ? "avg_bin7" : "peak_bin7");
            do_read(0, 40, model_read(0, 40), "group_bin40");
        end

        // Wrap with saturating fill
        do_reset();
        check("wrap_reset_filled", rows_filled, 0);
        mode = 2'd0; avg_log2 = 2'd0;
        for (int k = 0; k < 6; k++) begin
            for (int b = 0; b < NUM_BINS; b++) spec[b] = $urandom % 256;
            spec[0] = k;
            send_spec(NUM_BINS);
        end
        check_state("wrap");
        check("wrap_filled_sat", rows_filled, 3);
        do_read(0, 0, 5, "wrap_r0");
        do_read(1, 0, 4, "wrap_r1");
        do_read(2, 0, 3, "wrap_r2");
        do_read(3, 0, 0, "wrap_r3_masked");

        // Length error mid-group
        mode = 2'd2; avg_log2 = 2'd1;
        for (int b = 0; b < NUM_BINS; b++) spec[b] = 50;
        send_spec(NUM_BINS);
        send_spec(101);
        check_state("lenerr");
        for (int b = 0; b < NUM_BINS; b++) spec[b] = 8;
        send_spec(NUM_BINS);
        for (int b = 0; b < NUM_BINS; b++) spec[b] = 12;
        send_spec(NUM_BINS);
        check_state("lenerr_recover");
        do_read(0, 0, 10, "lenerr_b0");
        do_read(0, 255, 10, "lenerr_b255");

        // Freeze at group start, then mid-group
        mode = 2'd0; avg_log2 = 2'd0; freeze = 1'b1;
        for (int k = 0; k < 2; k++) begin
            for (int b = 0; b < NUM_BINS; b++) spec[b] = 77;
            send_spec(NUM_BINS);
        end
        check_state("frozen");
        do_read(0, 0, 10, "frozen_keep");
        freeze = 1'b0;
        for (int b = 0; b < NUM_BINS; b++) spec[b] = 33;
        send_spec(NUM_BINS);
        check_state("unfrozen");
        do_read(0, 9, 33, "unfrozen_row");
        mode = 2'd1; avg_log2 = 2'd1;
        for (int b = 0; b < NUM_BINS; b++) spec[b] = 5;
        send_spec(NUM_BINS);
        freeze = 1'b1;
        for (int b = 0; b < NUM_BINS; b++) spec[b] = 9;
        send_spec(NUM_BINS);
        freeze = 1'b0;
        check_state("freeze_midgroup");
        do_read(0, 3, 9, "freeze_mid_row");

        // Reset mid-spectrum
        mode = 2'd0; avg_log2 = 2'd0;
        for (int i = 0; i < 200; i++) beat(i, 1'b0);
        do_reset();
        check("midrst_filled", rows_filled, 0);
        check("midrst_rd_valid", rd_valid, 0);
        for (int b = 0; b < NUM_BINS; b++) spec[b] = (b * 7 + 1) % 256;
        send_spec(NUM_BINS);
        check_state("midrst_after");
        do_read(0, 0, 1, "midrst_b0");
        do_read(0, 200, model_read(0, 200), "midrst_b200");
        do_read(1, 0, 0, "midrst_r1_masked");

        // Randomized spectra, controls and framing against the model
        gaps = 1'b1;
        for (int n = 0; n < 30; n++) begin
            int r;
            int len;
            int rr;
            int rb;
            mode     = 2'($urandom % 4);
            avg_log2 = 2'($urandom % 4);
            freeze   = ($urandom % 5 == 0);
            for (int b = 0; b < NUM_BINS; b++) spec[b] = $urandom % 256;
            r = $urandom % 10;
            if (r == 0) len = $urandom_range(1, NUM_BINS - 1);
            else if (r == 1) len = NUM_BINS + $urandom_range(1, 3);
            else len = NUM_BINS;
            send_spec(len);
            check_state("rand");
            rr = $urandom % NUM_ROWS;
            rb = $urandom % NUM_BINS;
            do_read(rr, rb, model_read(rr, rb), "rand_read");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
